// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch/decode/execute FSM driving the datapath,
// return stack, data bus and interrupt handshake.
module control_unit #(
    parameter logic INT_EN_RST = 1'b0
) (
    input  logic       clkg,
    input  logic       rst,
    input  logic [6:0] op_i,
    input  logic [2:0] func_i,
    input  logic       alu_z_i,
    input  logic       alu_c_i,
    input  logic       inst_ack_i,
    input  logic       data_ack_i,
    input  logic       int_req_i,
    output logic       inst_stb_o,
    output logic       ir_we_o,
    output logic       pc_en_o,
    output logic [2:0] pc_sel_o,
    output logic       stack_push_o,
    output logic       stack_pop_o,
    output logic [3:0] alu_fn_o,
    output logic       alu_imm_o,
    output logic       data_stb_o,
    output logic       data_we_o,
    output logic       port_o,
    output logic       reg_we_o,
    output logic       int_ack_o
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_WAIT, S_INT
    } state_t;

    state_t state, state_next;

    logic z_flag, c_flag, z_saved, c_saved, int_en;
    logic flag_load, flag_save, flag_restore, int_en_set, int_en_clr, goto_fetch;

    logic is_alui, is_shift, is_mem, is_alur, is_jump, is_branch, is_misc, br_taken;

    assign is_alui   = ~op_i[6];
    assign is_shift  = (op_i[6:4] == 3'b110);
    assign is_mem    = (op_i[6:5] == 2'b10);
    assign is_alur   = (op_i[6:3] == 4'b1110);
    assign is_jump   = (op_i[6:2] == 5'b11110);
    assign is_branch = (op_i[6:1] == 6'b111110);
    assign is_misc   = (op_i == 7'b1111110);

    // func_i[1] picks the flag, func_i[0] inverts it (bz, bnz, bc, bnc)
    assign br_taken = func_i[1] ? (c_flag ^ func_i[0]) : (z_flag ^ func_i[0]);

    always_ff @(posedge clkg or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        inst_stb_o   = 1'b0;
        ir_we_o      = 1'b0;
        pc_en_o      = 1'b0;
        pc_sel_o     = 3'b000;
        stack_push_o = 1'b0;
        stack_pop_o  = 1'b0;
        alu_fn_o     = 4'b0000;
        alu_imm_o    = 1'b0;
        data_stb_o   = 1'b0;
        data_we_o    = 1'b0;
        port_o       = 1'b0;
        reg_we_o     = 1'b0;
        int_ack_o    = 1'b0;
        flag_load    = 1'b0;
        flag_save    = 1'b0;
        flag_restore = 1'b0;
        int_en_set   = 1'b0;
        int_en_clr   = 1'b0;
        goto_fetch   = 1'b0;

        // Outputs are held low for the whole reset pulse, not just after it
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    inst_stb_o = 1'b1;
                    if (inst_ack_i) begin
                        ir_we_o    = 1'b1;
                        pc_en_o    = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: state_next = S_EXECUTE;
                S_EXECUTE: begin
                    if (is_alui || is_alur || is_shift) begin
                        alu_fn_o   = {is_shift, func_i};
                        alu_imm_o  = is_alui | is_shift;
                        flag_load  = 1'b1;
                        state_next = S_WRITEBACK;
                    end else if (is_mem) begin
                        alu_imm_o  = 1'b1;
                        state_next = S_MEM;
                    end else if (is_branch) begin
                        pc_en_o    = br_taken;
                        pc_sel_o   = br_taken ? 3'b001 : 3'b000;
                        goto_fetch = 1'b1;
                    end else if (is_jump) begin
                        pc_en_o      = 1'b1;
                        pc_sel_o     = 3'b010;
                        stack_push_o = func_i[2];
                        goto_fetch   = 1'b1;
                    end else if (is_misc) begin
                        case (func_i)
                            3'b000, 3'b001: begin
                                stack_pop_o  = 1'b1;
                                pc_en_o      = 1'b1;
                                pc_sel_o     = 3'b011;
                                flag_restore = func_i[0];
                                int_en_set   = func_i[0];
                                goto_fetch   = 1'b1;
                            end
                            3'b010: begin
                                int_en_set = 1'b1;
                                goto_fetch = 1'b1;
                            end
                            3'b011: begin
                                int_en_clr = 1'b1;
                                goto_fetch = 1'b1;
                            end
                            3'b100, 3'b101: state_next = S_WAIT;
                            default: goto_fetch = 1'b1;
                        endcase
                    end else begin
                        goto_fetch = 1'b1;
                    end
                end
                S_MEM: begin
                    data_stb_o = 1'b1;
                    data_we_o  = op_i[3];
                    port_o     = op_i[4];
                    if (data_ack_i) begin
                        if (op_i[3]) goto_fetch = 1'b1;
                        else         state_next = S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    reg_we_o   = 1'b1;
                    goto_fetch = 1'b1;
                end
                S_WAIT: begin
                    if (int_en && int_req_i) state_next = S_INT;
                end
                S_INT: begin
                    int_ack_o    = 1'b1;
                    stack_push_o = 1'b1;
                    pc_en_o      = 1'b1;
                    pc_sel_o     = 3'b100;
                    flag_save    = 1'b1;
                    int_en_clr   = 1'b1;
                    state_next   = S_FETCH;
                end
                default: state_next = S_FETCH;
            endcase

            // INT itself returns straight to FETCH so a held request cannot re-enter it
            if (goto_fetch) state_next = (int_en && int_req_i) ? S_INT : S_FETCH;
        end
    end

    always_ff @(posedge clkg or posedge rst) begin
        if (rst) begin
            z_flag  <= 1'b0;
            c_flag  <= 1'b0;
            z_saved <= 1'b0;
            c_saved <= 1'b0;
            int_en  <= INT_EN_RST;
        end else begin
            if (flag_load) begin
                z_flag <= alu_z_i;
                c_flag <= alu_c_i;
            end else if (flag_restore) begin
                z_flag <= z_saved;
                c_flag <= c_saved;
            end
            if (flag_save) begin
                z_saved <= z_flag;
                c_saved <= c_flag;
            end
            if (int_en_set)      int_en <= 1'b1;
            else if (int_en_clr) int_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: instruction sequences with
// hand-computed per-cycle expectations.
module tb_control_unit;

    logic       clkg, rst;
    logic [6:0] op_i;
    logic [2:0] func_i;
    logic       alu_z_i, alu_c_i, inst_ack_i, data_ack_i, int_req_i;
    logic       inst_stb_o, ir_we_o, pc_en_o, stack_push_o, stack_pop_o;
    logic [2:0] pc_sel_o;
    logic [3:0] alu_fn_o;
    logic       alu_imm_o, data_stb_o, data_we_o, port_o, reg_we_o, int_ack_o;
    logic       any_out;

    int compare_count  = 0;
    int mismatch_count = 0;

    control_unit dut (
        .clkg(clkg), .rst(rst), .op_i(op_i), .func_i(func_i),
        .alu_z_i(alu_z_i), .alu_c_i(alu_c_i), .inst_ack_i(inst_ack_i),
        .data_ack_i(data_ack_i), .int_req_i(int_req_i),
        .inst_stb_o(inst_stb_o), .ir_we_o(ir_we_o), .pc_en_o(pc_en_o),
        .pc_sel_o(pc_sel_o), .stack_push_o(stack_push_o), .stack_pop_o(stack_pop_o),
        .alu_fn_o(alu_fn_o), .alu_imm_o(alu_imm_o), .data_stb_o(data_stb_o),
        .data_we_o(data_we_o), .port_o(port_o), .reg_we_o(reg_we_o),
        .int_ack_o(int_ack_o)
    );

    assign any_out = inst_stb_o | ir_we_o | pc_en_o | (|pc_sel_o) | stack_push_o |
                     stack_pop_o | (|alu_fn_o) | alu_imm_o | data_stb_o | data_we_o |
                     port_o | reg_we_o | int_ack_o;

    initial clkg = 1'b0;
    always #5 clkg = ~clkg;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkg);
        #1;
    endtask

    // Fetch (ack at once) and decode one instruction; returns in the EXECUTE cycle
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] func);
        op_i       = op;
        func_i     = func;
        inst_ack_i = 1'b1;
        @(negedge clkg);
        checkOutput("fetchIrWe", ir_we_o, 1);
        checkOutput("fetchPc", {pc_en_o, pc_sel_o}, 4'b1000);
        tick();
        inst_ack_i = 1'b0;
        @(negedge clkg);
        checkOutput("decodeIdle", any_out, 0);
        tick();
    endtask

    // ALU/shift instruction through EXECUTE and WRITEBACK
    task automatic aluOp(input logic [6:0] op, input logic [2:0] func, input logic z,
                         input logic c, input logic [3:0] exp_fn, input logic exp_imm);
        applyStimulus(op, func);
        alu_z_i = z;
        alu_c_i = c;
        @(negedge clkg);
        checkOutput("aluFn", alu_fn_o, exp_fn);
        checkOutput("aluImm", alu_imm_o, exp_imm);
        checkOutput("aluNoRegWe", reg_we_o, 0);
        tick();
        alu_z_i = 1'b0;
        alu_c_i = 1'b0;
        @(negedge clkg);
        checkOutput("wbRegWe", reg_we_o, 1);
        checkOutput("wbNoFetch", inst_stb_o, 0);
        tick();
    endtask

    initial begin
        int stb_cycles;
        int bad_cycles;
        rst = 1'b1; op_i = '0; func_i = '0; alu_z_i = 0; alu_c_i = 0;
        inst_ack_i = 0; data_ack_i = 0; int_req_i = 0;

        repeat (2) tick();
        @(negedge clkg);
        checkOutput("rstIdle", any_out, 0);
        tick();
        rst = 1'b0;
        @(negedge clkg);
        checkOutput("stbAfterRst", inst_stb_o, 1);
        checkOutput("irWeNoAck", ir_we_o, 0);
        tick();
        @(negedge clkg);
        checkOutput("holdNoAck", inst_stb_o, 1);
        tick();

        // ALU-register add-style op, sets Z
        aluOp(7'b1110000, 3'b001, 1'b1, 1'b0, 4'b0001, 1'b0);
        @(negedge clkg);
        checkOutput("aluBackToFetch", inst_stb_o, 1);
        tick();

        applyStimulus(7'b1111100, 3'b000);
        @(negedge clkg);
        checkOutput("bzTaken", {pc_en_o, pc_sel_o}, 4'b1001);
        tick();

        aluOp(7'b0000000, 3'b010, 1'b0, 1'b0, 4'b0010, 1'b1);
        applyStimulus(7'b1111100, 3'b000);
        @(negedge clkg);
        checkOutput("bzNotTaken", {pc_en_o, pc_sel_o}, 4'b0000);
        tick();

        aluOp(7'b1100000, 3'b011, 1'b0, 1'b1, 4'b1011, 1'b1);
        applyStimulus(7'b1111100, 3'b010);
        @(negedge clkg);
        checkOutput("bcTaken", {pc_en_o, pc_sel_o}, 4'b1001);
        tick();

        // ldm with ack on the 4th MEM cycle
        applyStimulus(7'b1000000, 3'b000);
        @(negedge clkg);
        checkOutput("ldmAddrImm", alu_imm_o, 1);
        checkOutput("ldmExecNoStb", data_stb_o, 0);
        tick();
        stb_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            data_ack_i = (i == 3);
            @(negedge clkg);
            if (data_stb_o) stb_cycles++;
            checkOutput("ldmWe", {data_we_o, port_o}, 2'b00);
            tick();
        end
        data_ack_i = 1'b0;
        checkOutput("ldmStbCycles", stb_cycles, 4);
        @(negedge clkg);
        checkOutput("ldmRegWe", reg_we_o, 1);
        checkOutput("ldmStbDrop", data_stb_o, 0);
        tick();

        applyStimulus(7'b1001000, 3'b000);
        tick();
        data_ack_i = 1'b1;
        @(negedge clkg);
        checkOutput("stmBus", {data_stb_o, data_we_o, port_o}, 3'b110);
        tick();
        data_ack_i = 1'b0;
        @(negedge clkg);
        checkOutput("stmToFetch", {inst_stb_o, reg_we_o}, 2'b10);
        tick();

        applyStimulus(7'b1011000, 3'b000);
        tick();
        data_ack_i = 1'b1;
        @(negedge clkg);
        checkOutput("outBus", {data_stb_o, data_we_o, port_o}, 3'b111);
        tick();
        data_ack_i = 1'b0;

        applyStimulus(7'b1111000, 3'b100);
        @(negedge clkg);
        checkOutput("jsb", {pc_en_o, pc_sel_o, stack_push_o}, 5'b10101);
        tick();

        // enai is deferred by one instruction even with a request pending
        aluOp(7'b0000000, 3'b000, 1'b1, 1'b1, 4'b0000, 1'b1);
        applyStimulus(7'b1111110, 3'b010);
        int_req_i = 1'b1;
        @(negedge clkg);
        checkOutput("enaiNoJump", pc_en_o, 0);
        tick();
        @(negedge clkg);
        checkOutput("enaiDeferred", {inst_stb_o, int_ack_o}, 2'b10);
        tick();
        aluOp(7'b0000000, 3'b001, 1'b0, 1'b0, 4'b0001, 1'b1);
        @(negedge clkg);
        checkOutput("intAck", {int_ack_o, stack_push_o, pc_en_o, pc_sel_o}, 6'b111100);
        checkOutput("intNoFetch", inst_stb_o, 0);
        int_req_i = 1'b0;
        tick();

        // flags become 1/1, reti must bring back the saved 0/0
        aluOp(7'b0000000, 3'b000, 1'b1, 1'b1, 4'b0000, 1'b1);
        applyStimulus(7'b1111110, 3'b001);
        @(negedge clkg);
        checkOutput("reti", {stack_pop_o, pc_en_o, pc_sel_o}, 5'b11011);
        tick();
        applyStimulus(7'b1111100, 3'b000);
        @(negedge clkg);
        checkOutput("bzAfterReti", pc_en_o, 0);
        tick();
        applyStimulus(7'b1111100, 3'b011);
        int_req_i = 1'b1;
        @(negedge clkg);
        checkOutput("bncAfterReti", {pc_en_o, pc_sel_o}, 4'b1001);
        tick();
        @(negedge clkg);
        checkOutput("intAfterReti", int_ack_o, 1);
        int_req_i = 1'b0;
        tick();

        // wait with interrupts disabled never wakes
        applyStimulus(7'b1111110, 3'b100);
        int_req_i = 1'b1;
        @(negedge clkg);
        checkOutput("waitExec", any_out, 0);
        tick();
        bad_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clkg);
            if (any_out) bad_cycles++;
            tick();
        end
        checkOutput("waitStuck", bad_cycles, 0);

        rst = 1'b1;
        @(negedge clkg);
        checkOutput("rstInWait", any_out, 0);
        tick();
        rst = 1'b0;
        int_req_i = 1'b0;
        @(negedge clkg);
        checkOutput("fetchAfterWait", inst_stb_o, 1);
        tick();

        // asynchronous reset in the middle of a bus cycle
        applyStimulus(7'b1000000, 3'b000);
        tick();
        @(negedge clkg);
        checkOutput("memBeforeRst", data_stb_o, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstMidMem", data_stb_o, 0);
        checkOutput("rstMidMemIdle", any_out, 0);
        tick();
        rst = 1'b0;
        @(negedge clkg);
        checkOutput("fetchAfterRst", {inst_stb_o, data_stb_o}, 2'b10);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: INT_EN_RST, default 1'b0, reset value of the interrupt-enable flag.
REQ-002 clkg  input  1  gated core clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op_i  input  7  opcode field from instruction register (instruction bits 17:11).
REQ-005 func_i  input  3  function field from instruction register.
REQ-006 alu_z_i, alu_c_i  input  1 each  zero/carry result of the current ALU operation.
REQ-007 inst_ack_i, data_ack_i  input  1 each  instruction-memory and data-bus acknowledges.
REQ-008 int_req_i  input  1  level-sensitive interrupt request.
REQ-009 inst_stb_o  output  1  instruction fetch request.
REQ-010 ir_we_o  output  1  instruction register write enable.
REQ-011 pc_en_o  output  1  PC load enable; pc_sel_o  output  3  PC source: 000 PC+1, 001 branch, 010 jump address, 011 stack pop, 100 interrupt vector.
REQ-012 stack_push_o, stack_pop_o  output  1 each  return-stack controls.
REQ-013 alu_fn_o  output  4  {shift_class, func_i} for datapath ALU; alu_imm_o  output  1  select immediate operand.
REQ-014 data_stb_o, data_we_o, port_o  output  1 each  data-bus strobe, write, I/O-space select.
REQ-015 reg_we_o  output  1  register-file write enable.
REQ-016 int_ack_o  output  1  one-cycle interrupt acknowledge.

Function
REQ-017 Class decode from op_i: bit6=0 ALU-immediate; 6:4=110 shift; 6:5=10 memory; 6:3=1110 ALU-register; 6:2=11110 jump; 6:1=111110 branch; 1111110 misc; 1111111 illegal, executed as no-op.
REQ-018 Memory subtype = op_i[4:3]: 00 ldm, 01 stm, 10 inp, 11 out; jump: func_i[2]=0 jmp, 1 jsb; branch: func_i[1:0] 00 bz, 01 bnz, 10 bc, 11 bnc; misc: func_i 000 ret, 001 reti, 010 enai, 011 disi, 100 wait, 101 stby, 11x no-op.
REQ-019 States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, WAIT, INT; one-hot or binary encoding at implementer's choice.
REQ-020 FETCH: inst_stb_o=1 until inst_ack_i; in the ack cycle ir_we_o=1, pc_en_o=1, pc_sel_o=000, next DECODE; no ack -> stay.
REQ-021 DECODE: single cycle, no outputs asserted, next EXECUTE.
REQ-022 EXECUTE ALU/shift: alu_fn_o valid, alu_imm_o=1 for immediate and shift classes; Z/C flags latched from alu_z_i/alu_c_i; next WRITEBACK.
REQ-023 EXECUTE memory: alu_imm_o=1 (address calc), next MEM.
REQ-024 EXECUTE branch: if condition true on registered Z/C, pc_en_o=1, pc_sel_o=001; next FETCH.
REQ-025 EXECUTE jump: pc_en_o=1, pc_sel_o=010; jsb also stack_push_o=1; next FETCH.
REQ-026 EXECUTE misc: ret -> stack_pop_o=1, pc_en_o=1, pc_sel_o=011; reti -> same plus Z/C restored from saved copy and int_en set; enai sets, disi clears int_en; wait/stby -> next WAIT; others next FETCH.
REQ-027 MEM: data_stb_o=1, data_we_o=1 for stm/out, port_o=1 for inp/out, held until data_ack_i; on ack ldm/inp -> WRITEBACK, stm/out -> FETCH.
REQ-028 WRITEBACK: reg_we_o=1 for one cycle, next FETCH.
REQ-029 Interrupt check: on every transition that would enter FETCH, if int_en and int_req_i (values before this edge's update) then enter INT instead; enai therefore takes effect after the following instruction.
REQ-030 INT: single cycle; int_ack_o=1, stack_push_o=1, pc_en_o=1, pc_sel_o=100; Z/C copied to saved flags; int_en cleared; next FETCH.
REQ-031 WAIT: no outputs; leave to INT when int_en and int_req_i; with int_en=0 remain until reset.
REQ-032 Zero-wait latency: ALU 4 cycles, branch/jump/misc 3, store 4, load 5, plus INT 1 when taken.
REQ-033 All outputs not explicitly asserted in a state are 0.

Reset
REQ-034 rst=1 forces FETCH asynchronously at any state, including mid-MEM with data_stb_o high.
REQ-035 Reset values: all outputs 0, Z=C=0, saved Z/C=0, int_en=INT_EN_RST; inst_stb_o rises first cycle after rst deasserts.

Verification
REQ-036 ALU-register op_i=1110000, func 001, acks immediate -> ir_we_o cycle 1, EXECUTE alu_fn_o=0001, reg_we_o cycle 4.
REQ-037 ldm with data_ack_i delayed 3 cycles -> data_stb_o high 4 cycles, data_we_o=0, reg_we_o one cycle after ack.
REQ-038 Z=1 then bz -> pc_sel_o=001 pulse; Z=0 then bz -> no pc_en_o in EXECUTE.
REQ-039 enai, then int_req_i=1 during next ALU op -> INT after its WRITEBACK: int_ack_o, stack_push_o, pc_sel_o=100 same cycle; reti restores Z/C and int_en=1.
REQ-040 wait with int_en=0 -> stays WAIT 100 cycles despite int_req_i; rst mid-MEM -> data_stb_o=0 immediately, FETCH after release.
